// File: rtl/logic_ops_pkg.sv
// Opcode and FSM encodings shared by the logic unit arbiter and the gate datapath.
package logic_ops_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise logic unit; the reserved opcode yields zero data and err=1.
module logic_op_unit
  import logic_ops_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] data,
  output logic             err
);
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (op)
      OP_AND:  data = a & b;
      OP_OR:   data = a | b;
      OP_NOT:  data = ~a;
      OP_NAND: data = ~(a & b);
      OP_NOR:  data = ~(a | b);
      OP_XOR:  data = a ^ b;
      OP_XNOR: data = ~(a ^ b);
      default: err  = 1'b1;
    endcase
  end
endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin shares one registered logic unit among NUM_REQ requesters;
// IDLE grants and latches, EXEC registers the result, RESP holds it until taken.
module logic_unit_arbiter
  import logic_ops_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]  req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic                     busy
);
  state_t state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant;
  logic             req_any;
  logic [ID_W-1:0]  cand;
  logic [WIDTH-1:0] op_a, op_b;
  logic [OP_W-1:0]  op_code;
  logic [ID_W-1:0]  op_id;
  logic [WIDTH-1:0] alu_data;
  logic             alu_err;

  logic [NUM_REQ-1:0][WIDTH-1:0] a_lane, b_lane;
  logic [NUM_REQ-1:0][OP_W-1:0]  op_lane;
  logic [NUM_REQ-1:0]            grant_oh;

  assign a_lane  = req_a;
  assign b_lane  = req_b;
  assign op_lane = req_op;

  // First valid requester at or above rr_ptr, wrapping.
  always_comb begin
    grant   = '0;
    req_any = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!req_any && req_valid[cand]) begin
        req_any = 1'b1;
        grant   = cand;
      end
    end
  end

  assign grant_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;
  assign req_ready = (state == IDLE && req_any && !rst) ? grant_oh : '0;
  assign busy      = (state != IDLE);

  logic_op_unit #(.WIDTH(WIDTH)) u_op (
    .a    (op_a),
    .b    (op_b),
    .op   (op_code),
    .data (alu_data),
    .err  (alu_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_code   <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_any) begin
          op_a    <= a_lane[grant];
          op_b    <= b_lane[grant];
          op_code <= op_lane[grant];
          op_id   <= grant;
          rr_ptr  <= (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + ID_W'(1);
          state   <= EXEC;
        end
        EXEC: begin
          rsp_data  <= alu_data;
          rsp_err   <= alu_err;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: op table plus fairness, backpressure, reset, withdrawal.
module tb_logic_unit_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic [11:0] req_op;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_err, busy;

  int tests = 0;
  int fails = 0;

  logic_unit_arbiter #(.NUM_REQ(4), .WIDTH(8), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] d;
    logic       e;
  } vec_t;
  vec_t vt[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_op[i*3 +: 3] = op;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Starts in IDLE just after an edge; runs one op through EXEC and RESP with rsp_ready=1.
  task automatic txn(input logic [3:0] vld, input int gid, input logic [7:0] ed,
                     input logic ee, input bit hold);
    logic [3:0] oh;
    oh = 4'b0001 << gid;
    req_valid = vld;
    @(negedge clk);
    check("grant", {28'd0, req_ready}, {28'd0, oh});
    step();
    if (!hold) req_valid = 4'b0000;
    check("exec_busy", {31'd0, busy}, 32'd1);
    check("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("exec_ready", {28'd0, req_ready}, 32'd0);
    step();
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rsp_id", {30'd0, rsp_id}, gid);
    check("rsp_data", {24'd0, rsp_data}, {24'd0, ed});
    check("rsp_err", {31'd0, rsp_err}, {31'd0, ee});
    step();
    check("rsp_done", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_ready"}, {28'd0, req_ready}, 32'd0);
    check({nm, "_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({nm, "_id"},    {30'd0, rsp_id}, 32'd0);
    check({nm, "_data"},  {24'd0, rsp_data}, 32'd0);
    check({nm, "_err"},   {31'd0, rsp_err}, 32'd0);
    check({nm, "_busy"},  {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] hd, hi;
    logic       he;
    vt[0]  = '{0, 8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0};
    vt[1]  = '{1, 8'hF0, 8'h3C, 3'd1, 8'hFC, 1'b0};
    vt[2]  = '{2, 8'hF0, 8'h3C, 3'd2, 8'h0F, 1'b0};
    vt[3]  = '{3, 8'hF0, 8'h3C, 3'd3, 8'hCF, 1'b0};
    vt[4]  = '{0, 8'hF0, 8'h3C, 3'd4, 8'h03, 1'b0};
    vt[5]  = '{1, 8'hF0, 8'h3C, 3'd5, 8'hCC, 1'b0};
    vt[6]  = '{2, 8'hF0, 8'h3C, 3'd6, 8'h33, 1'b0};
    vt[7]  = '{3, 8'hF0, 8'h3C, 3'd7, 8'h00, 1'b1};
    vt[8]  = '{1, 8'hAA, 8'h55, 3'd5, 8'hFF, 1'b0};
    vt[9]  = '{2, 8'hAA, 8'h55, 3'd0, 8'h00, 1'b0};
    vt[10] = '{0, 8'hFF, 8'hFF, 3'd3, 8'h00, 1'b0};
    vt[11] = '{3, 8'h00, 8'h5A, 3'd2, 8'hFF, 1'b0};

    rst = 1'b1; rsp_ready = 1'b1; req_valid = '0;
    req_a = '0; req_b = '0; req_op = '0;
    step(); step();
    check_zero("reset");
    rst = 1'b0;
    step();

    // Op table, one requester at a time
    for (int i = 0; i < 12; i++) begin
      set_lane(vt[i].id, vt[i].a, vt[i].b, vt[i].op);
      txn(4'b0001 << vt[i].id, vt[i].id, vt[i].d, vt[i].e, 1'b0);
    end

    // Fairness: all four held from a fresh rr_ptr
    rst = 1'b1; #1; rst = 1'b0;
    step();
    set_lane(0, 8'h11, 8'hFF, 3'd0);
    set_lane(1, 8'h22, 8'h00, 3'd1);
    set_lane(2, 8'h33, 8'h00, 3'd2);
    set_lane(3, 8'h44, 8'h0F, 3'd5);
    for (int g = 0; g < 5; g++) begin
      case (g % 4)
        0: hd = 8'h11;
        1: hd = 8'h22;
        2: hd = 8'hCC;
        default: hd = 8'h4B;
      endcase
      txn(4'b1111, g % 4, hd, 1'b0, 1'b1);
    end
    req_valid = '0;
    step();

    // Backpressure: rr_ptr=1, requester 1 XOR 0F^FF=F0
    set_lane(1, 8'h0F, 8'hFF, 3'd5);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    step();
    req_valid = 4'b1001;
    step();
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_data", {24'd0, rsp_data}, 32'hF0);
      check("bp_id", {30'd0, rsp_id}, 32'd1);
      check("bp_err", {31'd0, rsp_err}, 32'd0);
      check("bp_ready", {28'd0, req_ready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    check("bp_idle_busy", {31'd0, busy}, 32'd0);
    check("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);

    // Async reset in EXEC, then rr_ptr restarts at 0
    set_lane(1, 8'h12, 8'h34, 3'd1);
    req_valid = 4'b0010;
    step();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    req_valid = 4'b0100;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    step();
    rst = 1'b0;
    set_lane(2, 8'hC3, 8'hFF, 3'd6);
    txn(4'b0100, 2, 8'hC3, 1'b0, 1'b0);

    // Withdrawn request during another op's RESP; rr_ptr=3 -> grant 0 -> rr_ptr=1
    set_lane(0, 8'h0F, 8'h00, 3'd1);
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    step();
    req_valid = 4'b0010;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("wd_ready", {28'd0, req_ready}, 32'd0);
      step();
    end
    req_valid = 4'b0000;
    check("wd_rsp_id", {30'd0, rsp_id}, 32'd0);
    rsp_ready = 1'b1;
    step();
    // From rr_ptr=1, {3,1} must pick 1; a moved pointer would pick 3
    set_lane(1, 8'h5A, 8'hA5, 3'd4);
    set_lane(3, 8'hFF, 8'h00, 3'd0);
    hi = 8'h00; he = 1'b0;
    txn(4'b1010, 1, hi, he, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
